// File: rtl/mem_bridge.sv
// mem_bridge: turns the core's size/sign memory accesses into word-aligned req/ack bus cycles.
// Define MEM_MISALIGN_SPLIT_EN to split misaligned accesses into two bus words instead of erroring.
`ifndef XLEN
`define XLEN 32
`endif

module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [2:0]        cpu_mode,
  input  logic [`XLEN-1:0]  cpu_addr,
  input  logic [`XLEN-1:0]  cpu_wdata,
  output logic [`XLEN-1:0]  cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [`XLEN-1:0]  bus_addr,
  output logic [3:0]        bus_be,
  output logic [`XLEN-1:0]  bus_wdata,
  input  logic [`XLEN-1:0]  bus_rdata,
  input  logic              bus_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS0 = 2'd1;
  localparam logic [1:0] BUS1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic       WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYCLES - 1);

  function automatic logic mode_legal(input logic [2:0] mode);
    case (mode)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: mode_legal = 1'b1;
      default:                                mode_legal = 1'b0;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0, then sign/zero extend by mode[2].
  function automatic logic [31:0] load_extract(input logic [63:0] raw,
                                               input logic [1:0]  off,
                                               input logic [2:0]  mode);
    logic [31:0] shifted;
    shifted = 32'(raw >> {off, 3'b000});
    case (mode[1:0])
      2'b00:   load_extract = {{24{~mode[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_extract = {{16{~mode[2] & shifted[15]}}, shifted[15:0]};
      2'b10:   load_extract = shifted;
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]  state_r;
  logic        wen_r;
  logic [2:0]  mode_r;
  logic [1:0]  off_r;
  logic [9:0]  wd_cnt_r;
  logic [7:0]  size_mask_s;
  logic [7:0]  be8_s;
  logic [31:0] wdata_lo_s;
  logic        misalign_s;
  logic        accept_ok_s;
  logic        wd_expired_s;
  logic [63:0] raw_s;
  logic [31:0] load_data_s;
`ifdef MEM_MISALIGN_SPLIT_EN
  logic [31:0] wdata_hi_s;
  logic [3:0]  be_hi_r;
  logic [31:0] wdata_hi_r;
  logic        split_r;
  logic [31:0] lo_r;
`endif

  // Lane mask, lane-positioned store data and legality of the access being offered.
  always_comb begin
    case (cpu_mode[1:0])
      2'b00:   size_mask_s = 8'h01;
      2'b01:   size_mask_s = 8'h03;
      2'b10:   size_mask_s = 8'h0F;
      default: size_mask_s = 8'h00;
    endcase
    be8_s      = size_mask_s << cpu_addr[1:0];
    misalign_s = |be8_s[7:4];
`ifdef MEM_MISALIGN_SPLIT_EN
    {wdata_hi_s, wdata_lo_s} = {32'h0000_0000, cpu_wdata} << {cpu_addr[1:0], 3'b000};
    accept_ok_s = mode_legal(cpu_mode);
`else
    wdata_lo_s  = cpu_wdata << {cpu_addr[1:0], 3'b000};
    accept_ok_s = mode_legal(cpu_mode) & ~misalign_s;
`endif
  end

  // Load result assembly: the second word of a split read supplies the high half.
  always_comb begin
`ifdef MEM_MISALIGN_SPLIT_EN
    if (state_r == BUS1) begin
      raw_s = {bus_rdata, lo_r};
    end else begin
      raw_s = {32'h0000_0000, bus_rdata};
    end
`else
    raw_s = {32'h0000_0000, bus_rdata};
`endif
    load_data_s  = load_extract(raw_s, off_r, mode_r);
    wd_expired_s = WD_EN & (wd_cnt_r == WD_LAST);
  end

  // Access sequencer: accept, run one or two bus handshakes, then pulse the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      wen_r     <= 1'b0;
      mode_r    <= 3'b000;
      off_r     <= 2'b00;
      wd_cnt_r  <= 10'd0;
      cpu_rdata <= 32'h0000_0000;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
`ifdef MEM_MISALIGN_SPLIT_EN
      be_hi_r    <= 4'b0000;
      wdata_hi_r <= 32'h0000_0000;
      split_r    <= 1'b0;
      lo_r       <= 32'h0000_0000;
`endif
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cpu_req) begin
            wen_r  <= cpu_wen;
            mode_r <= cpu_mode;
            off_r  <= cpu_addr[1:0];
            if (accept_ok_s) begin
              state_r   <= BUS0;
              bus_req   <= 1'b1;
              bus_we    <= cpu_wen;
              bus_addr  <= {cpu_addr[31:2], 2'b00};
              bus_be    <= be8_s[3:0];
              bus_wdata <= wdata_lo_s;
              wd_cnt_r  <= 10'd0;
`ifdef MEM_MISALIGN_SPLIT_EN
              be_hi_r    <= be8_s[7:4];
              wdata_hi_r <= wdata_hi_s;
              split_r    <= misalign_s;
`endif
            end else begin
              state_r   <= RESP;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= 32'h0000_0000;
            end
          end
        end
        BUS0: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
`ifdef MEM_MISALIGN_SPLIT_EN
            if (split_r) begin
              lo_r      <= bus_rdata;
              bus_addr  <= bus_addr + 32'd4;
              bus_be    <= be_hi_r;
              bus_wdata <= wdata_hi_r;
              state_r   <= BUS1;
            end else begin
              state_r   <= RESP;
              cpu_ready <= 1'b1;
              if (!wen_r) begin
                cpu_rdata <= load_data_s;
              end
            end
`else
            state_r   <= RESP;
            cpu_ready <= 1'b1;
            if (!wen_r) begin
              cpu_rdata <= load_data_s;
            end
`endif
          end else if (wd_expired_s) begin
            bus_req   <= 1'b0;
            state_r   <= RESP;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= 32'h0000_0000;
          end else begin
            wd_cnt_r <= wd_cnt_r + 10'd1;
          end
        end
`ifdef MEM_MISALIGN_SPLIT_EN
        BUS1: begin
          // First BUS1 cycle leaves the bus idle; the second word is offered on the next.
          if (!bus_req) begin
            bus_req  <= 1'b1;
            wd_cnt_r <= 10'd0;
          end else if (bus_ack) begin
            bus_req   <= 1'b0;
            state_r   <= RESP;
            cpu_ready <= 1'b1;
            if (!wen_r) begin
              cpu_rdata <= load_data_s;
            end
          end else if (wd_expired_s) begin
            bus_req   <= 1'b0;
            state_r   <= RESP;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= 32'h0000_0000;
          end else begin
            wd_cnt_r <= wd_cnt_r + 10'd1;
          end
        end
`endif
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: scoreboard bench for mem_bridge covering lanes, extension, errors, watchdog and reset.
// Expectations for misaligned accesses follow MEM_MISALIGN_SPLIT_EN.
module tb_mem_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wen;
  logic [2:0]  cpu_mode;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } bus_txn_t;

  bus_txn_t    bus_q[$];
  logic [31:0] exp_rd_q[$];
  logic        exp_err_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          resp_en = 1'b1;
  int          stray_req = 0;
  int          stray_done = 0;
  int          req_cycles = 0;
  logic        prev_ready = 1'b0;

  mem_bridge #(.TIMEOUT_CYCLES(1023)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_wen  (cpu_wen),
    .cpu_mode (cpu_mode),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .cpu_err  (cpu_err),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_be   (bus_be),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    bus_txn_t t;
    t.addr  = addr;
    t.be    = be;
    t.we    = we;
    t.wdata = wdata;
    t.rdata = rdata;
    t.delay = delay;
    bus_q.push_back(t);
  endtask

  task automatic do_access(input string tag, input logic wen, input logic [2:0] mode,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    lat = 0;
    req_cycles = 0;
    exp_rd_q.push_back(exp_rdata);
    exp_err_q.push_back(exp_err);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_wen   = wen;
    cpu_mode  = mode;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int i = 1; i <= 1200 && lat == 0; i++) begin
      @(negedge clk);
      if (bus_req) req_cycles++;
      if (cpu_ready) lat = i;
    end
    cpu_req = 1'b0;
    check_val({tag, "_latency"}, lat, exp_lat);
  endtask

  // Bus slave: checks each offered transaction against the queue and acknowledges it.
  initial begin : bus_responder
    bus_txn_t t;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack = 1'b0;
        check_val("bus_req_drop", bus_req, 1'b0);
      end else if (stray_done != stray_req) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'hA5A5_A5A5;
        stray_done++;
      end else if (resp_en && bus_req) begin
        if (bus_q.size() == 0) begin
          check_val("bus_unexpected_req", bus_req, 1'b0);
        end else begin
          t = bus_q.pop_front();
          check_val("bus_addr", bus_addr, t.addr);
          check_val("bus_be", bus_be, t.be);
          check_val("bus_we", bus_we, t.we);
          if (t.we) check_val("bus_wdata", bus_wdata, t.wdata);
          for (int d = 0; d < t.delay; d++) begin
            @(negedge clk);
            check_val("bus_hold_req", bus_req, 1'b1);
            check_val("bus_hold_addr", bus_addr, t.addr);
          end
          bus_ack   = 1'b1;
          bus_rdata = t.rdata;
        end
      end
    end
  end

  // Response monitor: pops the expected result on every cpu_ready pulse.
  initial begin : cpu_monitor
    logic [31:0] er;
    logic        ee;
    forever begin
      @(negedge clk);
      if (prev_ready) check_val("ready_pulse", cpu_ready, 1'b0);
      if (!cpu_ready && cpu_err) check_val("err_without_ready", cpu_err, 1'b0);
      if (cpu_ready) begin
        if (exp_rd_q.size() == 0) begin
          check_val("ready_unexpected", cpu_ready, 1'b0);
        end else begin
          er = exp_rd_q.pop_front();
          ee = exp_err_q.pop_front();
          check_val("cpu_rdata", cpu_rdata, er);
          check_val("cpu_err", cpu_err, ee);
        end
      end
      prev_ready = cpu_ready;
    end
  end

  initial begin : global_guard
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish before 300000");
    $fatal(1, "bench stopped");
  end

  initial begin : main
    rst = 1'b1;
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_mode = 3'b000;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_val("rst_bus_req", bus_req, 1'b0);
    check_val("rst_bus_we", bus_we, 1'b0);
    check_val("rst_bus_addr", bus_addr, 32'h0);
    check_val("rst_bus_be", bus_be, 4'b0000);
    check_val("rst_bus_wdata", bus_wdata, 32'h0);
    check_val("rst_cpu_ready", cpu_ready, 1'b0);
    check_val("rst_cpu_err", cpu_err, 1'b0);
    check_val("rst_cpu_rdata", cpu_rdata, 32'h0);
    rst = 1'b0;

    exp_bus(32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_0000, 0);
    do_access("lb", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    exp_bus(32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_0000, 0);
    do_access("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h0000_0080, 1'b0, 2);
    exp_bus(32'h0000_2000, 4'b1100, 1'b1, 32'hABCD_0000, 32'hDEAD_BEEF, 0);
    do_access("sh", 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0000_0080, 1'b0, 2);
    exp_bus(32'h0000_7000, 4'b1100, 1'b0, 32'h0, 32'h8001_1234, 0);
    do_access("lh", 1'b0, 3'b001, 32'h0000_7002, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    do_access("illegal", 1'b0, 3'b110, 32'h0000_4000, 32'h0, 32'h0, 1'b1, 1);
`ifdef MEM_MISALIGN_SPLIT_EN
    exp_bus(32'h0000_3000, 4'b1110, 1'b0, 32'h0, 32'h4433_2211, 0);
    exp_bus(32'h0000_3004, 4'b0001, 1'b0, 32'h0, 32'h8877_6655, 0);
    do_access("lw_split", 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h5544_3322, 1'b0, 4);
`else
    do_access("lw_misalign", 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1'b1, 1);
`endif
    exp_bus(32'h0000_7000, 4'b1100, 1'b0, 32'h0, 32'h8001_1234, 0);
    do_access("lhu", 1'b0, 3'b101, 32'h0000_7002, 32'h0, 32'h0000_8001, 1'b0, 2);
    exp_bus(32'h0000_7000, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0, 3);
    do_access("sw_wait", 1'b1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 32'h0000_8001, 1'b0, 5);
    exp_bus(32'h0000_1000, 4'b0001, 1'b0, 32'h0, 32'h1122_337F, 0);
    do_access("lb_off0", 1'b0, 3'b000, 32'h0000_1000, 32'h0, 32'h0000_007F, 1'b0, 2);
    exp_bus(32'h0000_1000, 4'b0010, 1'b1, 32'h0000_A500, 32'h0, 0);
    do_access("sb", 1'b1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 32'h0000_007F, 1'b0, 2);

    resp_en = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_mode = 3'b010; cpu_addr = 32'h0000_6000;
    @(negedge clk);
    check_val("rst_pre_req", bus_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_req_drop", bus_req, 1'b0);
    check_val("rst_rdata_clear", cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stray_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("stray_bus_req", bus_req, 1'b0);
      check_val("stray_ready", cpu_ready, 1'b0);
    end
    resp_en = 1'b1;
    exp_bus(32'h0000_6000, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF, 0);
    do_access("lw_after_rst", 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 1'b0, 2);

`ifdef MEM_MISALIGN_SPLIT_EN
    exp_bus(32'hFFFF_FFFC, 4'b1000, 1'b0, 32'h0, 32'hAB00_0000, 0);
    exp_bus(32'h0000_0000, 4'b0001, 1'b0, 32'h0, 32'h0000_00CD, 0);
    do_access("lh_wrap", 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_CDAB, 1'b0, 4);
`else
    do_access("lh_wrap", 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1);
`endif

    resp_en = 1'b0;
    do_access("lw_timeout", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 1'b1, 1024);
    check_val("wd_req_cycles", req_cycles, 1023);
    check_val("wd_req_low", bus_req, 1'b0);
    resp_en = 1'b1;

    repeat (4) @(negedge clk);
    check_val("exp_q_left", exp_rd_q.size(), 0);
    check_val("bus_q_left", bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
